// File: rtl/vending_change_dispenser.sv
// rtl/vending_change_dispenser.sv - greedy coin change payout from on-board stock (10,5,2,1).
// Optional CHANGE_STATS_EN adds total_paid/coins_paid payout counters.
module vending_change_dispenser #(
  parameter int AMT_W    = 8,
  parameter int INV_W    = 6,
  parameter int INV_INIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [3:0]       coin_value,
  input  logic             coin_ready,
  input  logic             refill_valid,
  input  logic [1:0]       refill_denom,
  input  logic [INV_W-1:0] refill_count,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [3:0]       stock_empty
`ifdef CHANGE_STATS_EN
  ,
  output logic [15:0]      total_paid,
  output logic [15:0]      coins_paid
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EMIT, S_DONE} state_t;

  state_t           state;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] stock [4];
  logic [INV_W-1:0] stock_nxt [4];
  logic [1:0]       sel_d;
  logic             pick_found;
  logic [1:0]       pick_d;
  logic             coin_take;

  function automatic logic [3:0] den_value(input logic [1:0] d);
    case (d)
      2'd0:    den_value = 4'd10;
      2'd1:    den_value = 4'd5;
      2'd2:    den_value = 4'd2;
      default: den_value = 4'd1;
    endcase
  endfunction

  assign busy      = (state != S_IDLE);
  assign coin_take = (state == S_EMIT) && coin_ready;

  // Scan smallest to largest so the largest affordable in-stock denomination wins.
  always_comb begin
    pick_found = 1'b0;
    pick_d     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((AMT_W'(den_value(2'(i))) <= remaining) && (stock[i] != '0)) begin
        pick_found = 1'b1;
        pick_d     = 2'(i);
      end
    end
  end

  // Dispense and refill may hit the same counter on one edge; the sum saturates.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [INV_W:0] sum;
      sum = {1'b0, stock[i]};
      if (coin_take && (sel_d == 2'(i)))
        sum = sum - 1'b1;
      if (refill_valid && (refill_denom == 2'(i)))
        sum = sum + {1'b0, refill_count};
      stock_nxt[i] = sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
      stock_empty[i] = (stock[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      coin_valid <= 1'b0;
      coin_value <= 4'd0;
      done       <= 1'b0;
      shortfall  <= '0;
      remaining  <= '0;
      sel_d      <= 2'd0;
      for (int i = 0; i < 4; i++)
        stock[i] <= INV_W'(INV_INIT);
    end else begin
      for (int i = 0; i < 4; i++)
        stock[i] <= stock_nxt[i];
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            remaining <= req_amount;
            req_ready <= 1'b0;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (pick_found) begin
            coin_value <= den_value(pick_d);
            sel_d      <= pick_d;
            coin_valid <= 1'b1;
            state      <= S_EMIT;
          end else begin
            done      <= 1'b1;
            shortfall <= remaining;
            state     <= S_DONE;
          end
        end
        S_EMIT: begin
          if (coin_ready) begin
            remaining  <= remaining - AMT_W'(coin_value);
            coin_valid <= 1'b0;
            coin_value <= 4'd0;
            state      <= S_SELECT;
          end
        end
        default: begin
          done      <= 1'b0;
          shortfall <= '0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CHANGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      total_paid <= 16'd0;
      coins_paid <= 16'd0;
    end else if (coin_take) begin
      total_paid <= total_paid + 16'(coin_value);
      coins_paid <= coins_paid + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vending_change_dispenser.sv
// tb/tb_vending_change_dispenser.sv - directed and randomized checks against a payout model.
module tb_vending_change_dispenser;

  localparam int M_IDLE = 0, M_SELECT = 1, M_EMIT = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic       coin_ready;
  logic       refill_valid;
  logic [1:0] refill_denom;
  logic [5:0] refill_count;
  logic       busy;
  logic       done;
  logic [7:0] shortfall;
  logic [3:0] stock_empty;
`ifdef CHANGE_STATS_EN
  logic [15:0] total_paid;
  logic [15:0] coins_paid;
`endif

  vending_change_dispenser dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .coin_valid(coin_valid), .coin_value(coin_value),
    .coin_ready(coin_ready), .refill_valid(refill_valid), .refill_denom(refill_denom),
    .refill_count(refill_count), .busy(busy), .done(done), .shortfall(shortfall),
    .stock_empty(stock_empty)
`ifdef CHANGE_STATS_EN
    , .total_paid(total_paid), .coins_paid(coins_paid)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  bit armed    = 1'b0;
  int coin_log[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Payout model: phase of the current payout, amount still owed, coin stock.
  int m_phase, m_rem, m_coin, m_d, m_sum, m_cnt;
  int m_stock[4];

  function automatic int value_of(input int d);
    case (d)
      0: return 10;
      1: return 5;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int greedy_pick();
    for (int i = 0; i < 4; i++)
      if (value_of(i) <= m_rem && m_stock[i] != 0) return i;
    return -1;
  endfunction

  function automatic int next_stock(input int d);
    int s;
    s = m_stock[d];
    if (m_phase == M_EMIT && coin_ready && m_d == d) s = s - 1;
    if (refill_valid && int'(refill_denom) == d) s = s + int'(refill_count);
    if (s > 63) s = 63;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= M_IDLE;
      m_rem   <= 0;
      m_coin  <= 0;
      m_d     <= 0;
      m_sum   <= 0;
      m_cnt   <= 0;
      for (int i = 0; i < 4; i++) m_stock[i] <= 8;
    end else begin
      for (int i = 0; i < 4; i++) m_stock[i] <= next_stock(i);
      case (m_phase)
        M_IDLE:
          if (req_valid) begin
            m_rem   <= int'(req_amount);
            m_phase <= M_SELECT;
          end
        M_SELECT:
          if (greedy_pick() < 0) m_phase <= M_DONE;
          else begin
            m_d     <= greedy_pick();
            m_coin  <= value_of(greedy_pick());
            m_phase <= M_EMIT;
          end
        M_EMIT:
          if (coin_ready) begin
            m_rem   <= m_rem - m_coin;
            m_sum   <= (m_sum + m_coin) % 65536;
            m_cnt   <= (m_cnt + 1) % 65536;
            m_phase <= M_SELECT;
          end
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      int exp_empty;
      exp_empty = 0;
      for (int i = 0; i < 4; i++) if (m_stock[i] == 0) exp_empty |= (1 << i);
      chk("req_ready", int'(req_ready), int'(m_phase == M_IDLE));
      chk("busy", int'(busy), int'(m_phase != M_IDLE));
      chk("coin_valid", int'(coin_valid), int'(m_phase == M_EMIT));
      chk("done", int'(done), int'(m_phase == M_DONE));
      chk("shortfall", int'(shortfall), (m_phase == M_DONE) ? m_rem : 0);
      chk("stock_empty", int'(stock_empty), exp_empty);
      if (m_phase == M_EMIT) chk("coin_value", int'(coin_value), m_coin);
`ifdef CHANGE_STATS_EN
      chk("total_paid", int'(total_paid), m_sum);
      chk("coins_paid", int'(coins_paid), m_cnt);
`endif
      if (coin_valid && coin_ready) coin_log.push_back(int'(coin_value));
      if (done) n_done++;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_shortfall", int'(shortfall), 0);
    chk("rst_stock_empty", int'(stock_empty), 0);
  endtask

  task automatic send_req(input int amt);
    sync();
    req_valid  = 1'b1;
    req_amount = 8'(amt);
    sync();
    req_valid  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max, output int sh);
    sh = -1;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (done) begin
        sh = int'(shortfall);
        return;
      end
    end
    chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_coin(input string name, input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (coin_valid) return;
    end
    chk({name, "_coin_timeout"}, 0, 1);
  endtask

  initial begin
    int sh;
    int exp1[4];
    int cnt;
    rst = 1'b1; req_valid = 1'b0; req_amount = 8'd0; coin_ready = 1'b0;
    refill_valid = 1'b0; refill_denom = 2'd0; refill_count = 6'd0;
    sync();
    armed = 1'b1;

    // 18 pays 10,5,2,1 in order
    do_reset();
    coin_ready = 1'b1;
    coin_log.delete();
    send_req(18);
    wait_done("t1", 100, sh);
    exp1 = '{10, 5, 2, 1};
    chk("t1_ncoins", coin_log.size(), 4);
    for (int i = 0; i < 4 && i < coin_log.size(); i++) chk("t1_coin", coin_log[i], exp1[i]);
    chk("t1_short", sh, 0);
`ifdef CHANGE_STATS_EN
    chk("t1_total_paid", int'(total_paid), 18);
    chk("t1_coins_paid", int'(coins_paid), 4);
`endif

    // zero request: done in the cycle after edge N+1
    do_reset();
    coin_log.delete();
    sync();
    req_valid = 1'b1; req_amount = 8'd0;
    sync();
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t2_done", int'(done), 1);
    chk("t2_short", int'(shortfall), 0);
    chk("t2_coin_valid", int'(coin_valid), 0);
    @(negedge clk);
    chk("t2_req_ready", int'(req_ready), 1);
    chk("t2_ncoins", coin_log.size(), 0);

    // stock exhausted: 8*(10+5+2+1)=144 paid of 255
    do_reset();
    coin_ready = 1'b1;
    coin_log.delete();
    send_req(255);
    wait_done("t3", 400, sh);
    chk("t3_short", sh, 111);
    chk("t3_stock_empty", int'(stock_empty), 15);
    chk("t3_ncoins", coin_log.size(), 32);

    // back-pressure holds the coin steady
    do_reset();
    coin_ready = 1'b0;
    coin_log.delete();
    send_req(5);
    wait_coin("t4", 20);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", int'(coin_valid), 1);
      chk("t4_hold_value", int'(coin_value), 5);
    end
    sync();
    coin_ready = 1'b1;
    wait_done("t4", 20, sh);
    chk("t4_short", sh, 0);
    chk("t4_ncoins", coin_log.size(), 1);

    // refill on the dispense edge, then saturation
    do_reset();
    coin_ready = 1'b0;
    send_req(10);
    wait_coin("t5", 20);
    sync();
    coin_ready = 1'b1;
    refill_valid = 1'b1; refill_denom = 2'd0; refill_count = 6'd3;
    sync();
    refill_valid = 1'b0;
    chk("t5_model_stock10", m_stock[0], 10);
    wait_done("t5a", 20, sh);
    sync();
    refill_valid = 1'b1; refill_denom = 2'd0; refill_count = 6'd63;
    sync();
    refill_valid = 1'b0;
    chk("t5_model_stock_sat", m_stock[0], 63);
    send_req(255);
    wait_done("t5b", 200, sh);
    chk("t5_short_b", sh, 0);
    send_req(255);
    wait_done("t5c", 200, sh);
    chk("t5_short_c", sh, 0);
    send_req(255);
    wait_done("t5d", 300, sh);
    chk("t5_short_d", sh, 71);

    // reset during a presented coin
    do_reset();
    coin_ready = 1'b0;
    send_req(18);
    wait_coin("t6", 20);
    sync();
    rst = 1'b1;
    cnt = n_done;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_coin_valid", int'(coin_valid), 0);
    chk("t6_req_ready", int'(req_ready), 1);
    chk("t6_stock_empty", int'(stock_empty), 0);
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("t6_no_done", n_done, cnt);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      sync();
      rst          = ($urandom_range(0, 599) == 0);
      req_valid    = ($urandom_range(0, 3) == 0);
      req_amount   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      coin_ready   = ($urandom_range(0, 2) != 0);
      refill_valid = ($urandom_range(0, 11) == 0);
      refill_denom = 2'($urandom_range(0, 3));
      refill_count = 6'($urandom_range(0, 63));
    end
    sync();
    rst = 1'b0; req_valid = 1'b0; refill_valid = 1'b0; coin_ready = 1'b1;
    for (int k = 0; k < 10; k++) sync();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
